// File: rtl/multicycle_control.sv
// Multicycle processor control FSM with per-state memory wait timeout.
// Optional feature: define MC_JAL_EN to decode opcode 1101111 into the JAL state.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       instr_done,
  output logic       error,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef MC_JAL_EN
  localparam logic [6:0] OpJal    = 7'b1101111;
`endif

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluSub    = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
`ifdef MC_JAL_EN
    StJal,
`endif
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)             state_d = StDecode;
        else if (cnt_q == CntMax)  state_d = StError;
        else                       cnt_d   = cnt_q + CntOne;
      end
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
`ifdef MC_JAL_EN
          OpJal:           state_d = StJal;
`endif
          default:         state_d = StError;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)             state_d = StMemWb;
        else if (cnt_q == CntMax)  state_d = StError;
        else                       cnt_d   = cnt_q + CntOne;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (mem_ready)             state_d = StFetch;
        else if (cnt_q == CntMax)  state_d = StError;
        else                       cnt_d   = cnt_q + CntOne;
      end
      StExecR,
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
`ifdef MC_JAL_EN
      StJal:    state_d = StAluWb;
`endif
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase
    // The wait budget is per memory state, so it restarts on every entry.
    if (is_mem_state(state_d) && (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  // Output logic; everything is forced low while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    error      = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    alu_op     = AluAdd;
    result_src = ResAluOut;
    instr_done = !reset && (state_q != StFetch) && (state_d == StFetch);
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_a = SrcAPc;
          alu_src_b = SrcBFour;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_a = SrcAOldPc;
          alu_src_b = SrcBImm;
        end
        StMemAdr: begin
          alu_src_a = SrcARs1;
          alu_src_b = SrcBImm;
        end
        StMemRd: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          result_src = ResMem;
        end
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        StExecR: begin
          alu_src_a = SrcARs1;
          alu_src_b = SrcBRs2;
          alu_op    = AluFunct;
        end
        StExecI: begin
          alu_src_a = SrcARs1;
          alu_src_b = SrcBImm;
          alu_op    = AluFunct;
        end
        StAluWb: begin
          reg_write  = 1'b1;
          result_src = ResAluOut;
        end
        StBranch: begin
          alu_src_a = SrcARs1;
          alu_src_b = SrcBRs2;
          alu_op    = AluSub;
          pc_write  = zero;
        end
`ifdef MC_JAL_EN
        StJal: begin
          alu_src_a = SrcAOldPc;
          alu_src_b = SrcBFour;
          alu_op    = AluAdd;
          pc_write  = 1'b1;
        end
`endif
        StError: error = 1'b1;
        default: error = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of mem_ready-low wait cycles allowed per memory state.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  7  instruction-register opcode field, stable from DECODE until the instruction retires.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completion for the current request.
REQ-007 SHALL have output ports mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_done and error, each 1 bit wide.
REQ-008 SHALL have output ports alu_src_a (2 bits: 00 PC, 01 oldPC, 10 rs1), alu_src_b (2 bits: 00 rs2, 01 imm, 10 const 4), alu_op (2 bits: 00 add, 01 sub, 10 funct-decoded) and result_src (2 bits: 00 ALUOut, 01 mem data).

Function
REQ-009 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL and ERROR; any output not listed for a state SHALL be 0.
REQ-010 In FETCH it SHALL drive mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00; when mem_ready=1 it SHALL assert ir_write=1 and pc_write=1 combinationally and go to DECODE, otherwise stay in FETCH.
REQ-011 In DECODE it SHALL drive src_a=01, src_b=01, alu_op=00 (branch target) and go to MEMADR for 0000011 or 0100011, EXECR for 0110011, EXECI for 0010011, BRANCH for 1100011, JAL for 1101111, and ERROR for any other opcode.
REQ-012 In MEMADR it SHALL drive src_a=10, src_b=01, alu_op=00 and go to MEMRD for a load or MEMWR for a store.
REQ-013 In MEMRD it SHALL drive mem_req=1, adr_src=1 and go to MEMWB on mem_ready; in MEMWB it SHALL drive reg_write=1, result_src=01 and go to FETCH.
REQ-014 In MEMWR it SHALL drive mem_req=1, mem_we=1, adr_src=1 and go to FETCH on mem_ready.
REQ-015 EXECR SHALL drive src_a=10, src_b=00, alu_op=10; EXECI SHALL drive src_a=10, src_b=01, alu_op=10; both SHALL go to ALUWB, which SHALL drive reg_write=1, result_src=00 and go to FETCH.
REQ-016 In BRANCH it SHALL drive src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=zero (combinational) and go to FETCH.
REQ-017 In JAL it SHALL drive src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 and go to ALUWB.
REQ-018 SHALL pulse instr_done for exactly one cycle on every transition into FETCH from a state other than FETCH.
REQ-019 SHALL keep a wait counter sized for 0..MEM_TIMEOUT that clears on entry to any memory state (FETCH, MEMRD, MEMWR) and increments each cycle mem_ready=0 there.
REQ-020 In a memory state with mem_ready=0 and counter==MEM_TIMEOUT it SHALL go to ERROR; mem_ready=1 in that same cycle SHALL take priority and proceed normally.
REQ-021 ERROR SHALL drive error=1 with all enables and mem_req at 0, and SHALL be left only by reset.

Reset
REQ-022 On reset assertion the state SHALL become FETCH and the counter 0 asynchronously; all outputs SHALL be 0 while reset=1, including mem_req, so any outstanding access is abandoned.
REQ-023 After reset deasserts, the first rising edge SHALL evaluate FETCH with the counter at 0.

Configuration
REQ-024 Macro MC_JAL_EN: when it is defined, opcode 1101111 SHALL decode to JAL; when it is undefined, the JAL state SHALL be absent and 1101111 SHALL decode to ERROR.

Verification
REQ-025 Addi (0010011) with mem_ready=1 in FETCH -> FETCH, DECODE, EXECI, ALUWB; reg_write=1 only in ALUWB; instr_done pulses on the fourth cycle.
REQ-026 Load with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, adr_src=1, then MEMWB with reg_write=1, result_src=01.
REQ-027 Beq with zero=1 then zero=0 -> pc_write=1 in BRANCH for the first and 0 for the second; alu_op=01 in both.
REQ-028 FETCH with mem_ready held 0 for 16 cycles and MEM_TIMEOUT=15 -> ERROR with error=1; mem_ready=1 on cycle 16 instead -> DECODE.
REQ-029 Opcode 1111111 -> ERROR after DECODE; opcode 1101111 -> JAL when MC_JAL_EN is defined, otherwise ERROR.
REQ-030 Reset asserted mid-MEMWR -> mem_req and mem_we drop to 0 immediately; FETCH follows after reset release.
